// File: rtl/bldc_encoder.sv
// Quadrature/index encoder front end: sync, glitch filter, Gray-code decode, angle/position counters.
// Optional ENCODER_VELOCITY_EN adds a windowed signed velocity measurement; otherwise velocity is 0.
module bldc_encoder #(
  parameter int COUNTS     = 1024,
  parameter int FILTER     = 3,
  parameter int VEL_WINDOW = 100000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               enc_a,
  input  logic               enc_b,
  input  logic               enc_z,
  input  logic               index_en,
  input  logic               clear_err,
  output logic [15:0]        feedback,
  output logic signed [31:0] position,
  output logic               direction,
  output logic               index_seen,
  output logic               error,
  output logic [15:0]        velocity
);

  if (COUNTS < 2 || COUNTS > 65536 || FILTER < 1 || FILTER > 15 || VEL_WINDOW < 1) begin : g_bad_param
    $error("bldc_encoder: parameter out of range");
  end

  localparam logic [15:0] FB_MAX = 16'(COUNTS - 1);
  localparam logic [3:0]  FILT_N = 4'(FILTER);

  typedef enum logic [1:0] {S00 = 2'b00, S01 = 2'b01, S11 = 2'b11, S10 = 2'b10} state_t;

  // Pin vector order: [2]=A, [1]=B, [0]=Z
  logic [2:0] pins, sync1, sync2, flt;
  logic [3:0] flt_cnt [3];
  logic       z_q;
  state_t     state_q, state_d;
  logic       step_fwd, step_rev, illegal, z_rise;

  assign pins = {enc_a, enc_b, enc_z};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pins;
      sync2 <= sync1;
    end
  end

  // A change is accepted on the FILTER-th consecutive mismatching sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flt <= '0;
      for (int i = 0; i < 3; i++) flt_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == flt[i]) begin
          flt_cnt[i] <= '0;
        end else if (flt_cnt[i] == FILT_N - 4'd1) begin
          flt[i]     <= sync2[i];
          flt_cnt[i] <= '0;
        end else begin
          flt_cnt[i] <= flt_cnt[i] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S00;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      z_q     <= flt[0];
    end
  end

  always_comb begin
    state_d  = state_t'(flt[2:1]);
    step_fwd = 1'b0;
    step_rev = 1'b0;
    unique case (state_q)
      S00: begin step_fwd = (state_d == S01); step_rev = (state_d == S10); end
      S01: begin step_fwd = (state_d == S11); step_rev = (state_d == S00); end
      S11: begin step_fwd = (state_d == S10); step_rev = (state_d == S01); end
      S10: begin step_fwd = (state_d == S00); step_rev = (state_d == S11); end
      default: ;
    endcase
    illegal = ((state_q ^ state_d) == 2'b11);
    z_rise  = flt[0] & ~z_q;
  end

  // Index wins over a coincident step for feedback; position still counts the step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      feedback   <= '0;
      position   <= '0;
      direction  <= 1'b0;
      index_seen <= 1'b0;
    end else if (enable) begin
      if (index_en && z_rise) begin
        feedback   <= '0;
        index_seen <= 1'b1;
      end else if (step_fwd) begin
        feedback <= (feedback == FB_MAX) ? 16'd0 : feedback + 16'd1;
      end else if (step_rev) begin
        feedback <= (feedback == 16'd0) ? FB_MAX : feedback - 16'd1;
      end
      if (step_fwd) begin
        position  <= position + 32'sd1;
        direction <= 1'b1;
      end else if (step_rev) begin
        position  <= position - 32'sd1;
        direction <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         error <= 1'b0;
    else if (illegal)   error <= 1'b1;
    else if (clear_err) error <= 1'b0;
  end

`ifdef ENCODER_VELOCITY_EN
  localparam int WW = (VEL_WINDOW > 1) ? $clog2(VEL_WINDOW) : 1;
  logic [WW-1:0]      win_cnt;
  logic signed [15:0] acc;
  logic               win_end;

  assign win_end = (win_cnt == WW'(VEL_WINDOW - 1));

  // A step in the window's last cycle seeds the next window's accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt  <= '0;
      acc      <= '0;
      velocity <= '0;
    end else if (win_end) begin
      win_cnt  <= '0;
      velocity <= acc;
      if (enable && step_fwd)      acc <= 16'sd1;
      else if (enable && step_rev) acc <= -16'sd1;
      else                         acc <= '0;
    end else begin
      win_cnt <= win_cnt + 1'b1;
      if (enable && step_fwd && acc != 16'sd32767)       acc <= acc + 16'sd1;
      else if (enable && step_rev && acc != -16'sd32767) acc <= acc - 16'sd1;
    end
  end
`else
  assign velocity = '0;
`endif

endmodule

// File: tb/tb_bldc_encoder.sv
// Directed bench for bldc_encoder: driver tasks push expected {direction, position, feedback}
// into a queue; a negedge monitor pops and compares whenever feedback/position change.
module tb_bldc_encoder;
  localparam int COUNTS     = 1024;
  localparam int FILTER     = 3;
  localparam int VEL_WINDOW = 1000;
  localparam int W          = 49;

  logic               clk = 1'b0;
  logic               rst_n, enable, enc_a, enc_b, enc_z, index_en, clear_err;
  logic [15:0]        feedback, velocity;
  logic signed [31:0] position;
  logic               direction, index_seen, error;

  bldc_encoder #(.COUNTS(COUNTS), .FILTER(FILTER), .VEL_WINDOW(VEL_WINDOW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .enc_a(enc_a), .enc_b(enc_b), .enc_z(enc_z),
    .index_en(index_en), .clear_err(clear_err), .feedback(feedback), .position(position),
    .direction(direction), .index_seen(index_seen), .error(error), .velocity(velocity)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // ---------------- scoreboard state ----------------
  int             checks = 0, failures = 0;
  logic [W-1:0]   exp_q[$];
  logic [W-1:0]   e;
  logic [47:0]    cur, prev;
  bit             mon_en = 1'b0;
  int             first_cyc = -1;
  int             m_fb = 0, m_pos = 0, p = 0, t0, exp_vel;
  logic           m_dir = 1'b0;
  logic [1:0]     gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      cur = {feedback, position};
      if (cur !== prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_update: got fb=%0d pos=%0d expected no update", feedback, position);
        end else begin
          e = exp_q.pop_front();
          if (first_cyc < 0) first_cyc = cyc;
          check("upd_feedback", int'(feedback), int'(e[15:0]));
          check("upd_position", position, int'(e[47:16]));
          check("upd_direction", int'(direction), int'(e[48]));
        end
        prev = cur;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_pins(input logic [1:0] ab);
    enc_a = ab[1];
    enc_b = ab[0];
  endtask

  task automatic model_step(input bit fwd, input bit idx);
    if (enable) begin
      if (idx && index_en) m_fb = 0;
      else m_fb = fwd ? (m_fb + 1) % COUNTS : (m_fb + COUNTS - 1) % COUNTS;
      m_pos += fwd ? 1 : -1;
      m_dir = fwd;
      exp_q.push_back({m_dir, 32'(m_pos), 16'(m_fb)});
    end
  endtask

  task automatic step(input bit fwd, input int n_hold, input bit with_z);
    p = fwd ? (p + 1) % 4 : (p + 3) % 4;
    set_pins(gray[p]);
    if (with_z) enc_z = 1'b1;
    model_step(fwd, with_z);
    hold(n_hold);
    if (with_z) begin
      enc_z = 1'b0;
      hold(FILTER + 6);
    end
  endtask

  task automatic glitch_a(input int len);
    logic [1:0] tog;
    bit         fwd;
    tog = gray[p] ^ 2'b10;
    fwd = (gray[(p + 1) % 4] == tog);
    set_pins(tog);
    if (len >= FILTER) model_step(fwd, 1'b0);
    hold(len);
    set_pins(gray[p]);
    if (len >= FILTER) model_step(!fwd, 1'b0);
    hold(12);
  endtask

  task automatic illegal_jump(input bit with_clear);
    p = (p + 2) % 4;
    set_pins(gray[p]);
    if (with_clear) begin
      hold(FILTER + 2);
      clear_err = 1'b1;
      hold(1);
      clear_err = 1'b0;
      hold(10);
    end else begin
      hold(12);
    end
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    hold(1);
    clear_err = 1'b0;
    hold(2);
  endtask

  task automatic wait_phase(input int ph);
    hold(1);
    for (int i = 0; i < 2 * VEL_WINDOW && (cyc % VEL_WINDOW) != ph; i++) @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0; enable = 1'b1; index_en = 1'b0; clear_err = 1'b0;
    enc_a = 1'b0; enc_b = 1'b0; enc_z = 1'b0;
    hold(3);
    check("rst_feedback", int'(feedback), 0);
    check("rst_position", position, 0);
    check("rst_direction", int'(direction), 0);
    check("rst_index_seen", int'(index_seen), 0);
    check("rst_error", int'(error), 0);
    check("rst_velocity", int'(velocity), 0);
    rst_n = 1'b1;
    prev = '0;
    mon_en = 1'b1;
    hold(5);

    // 8 forward steps, first-count latency
    t0 = cyc;
    for (int i = 0; i < 8; i++) step(1'b1, 10, 1'b0);
    check("fwd8_feedback", int'(feedback), 8);
    check("fwd8_position", position, 8);
    check("fwd8_direction", int'(direction), 1);
    check("latency", first_cyc - t0, FILTER + 3);

    // back to 0, then reverse wrap
    for (int i = 0; i < 8; i++) step(1'b0, 10, 1'b0);
    check("back_feedback", int'(feedback), 0);
    for (int i = 0; i < 3; i++) step(1'b0, 10, 1'b0);
    check("revwrap_feedback", int'(feedback), 1021);
    check("revwrap_position", position, -3);
    check("revwrap_direction", int'(direction), 0);
    check("revwrap_error", int'(error), 0);

    // glitch filter
    glitch_a(2);
    check("glitch2_feedback", int'(feedback), 1021);
    glitch_a(3);
    check("glitch3_feedback", int'(feedback), 1021);
    check("glitch3_position", position, -3);

    // illegal transitions and clear priority
    illegal_jump(1'b0);
    check("illegal_error", int'(error), 1);
    check("illegal_feedback", int'(feedback), 1021);
    check("illegal_position", position, -3);
    pulse_clear();
    check("clear_error", int'(error), 0);
    illegal_jump(1'b1);
    check("set_beats_clear", int'(error), 1);
    pulse_clear();
    check("clear_error2", int'(error), 0);

    // enable=0 freezes counts, FSM keeps tracking
    enable = 1'b0;
    hold(2);
    step(1'b1, 10, 1'b0);
    step(1'b1, 10, 1'b0);
    check("frozen_feedback", int'(feedback), 1021);
    check("frozen_position", position, -3);
    enable = 1'b1;
    hold(10);
    check("reenable_error", int'(error), 0);
    step(1'b1, 10, 1'b0);
    check("reenable_feedback", int'(feedback), 1022);

    // forward wrap through 1023 -> 0 up to 500
    for (int i = 0; i < COUNTS && m_fb != 500; i++) step(1'b1, 6, 1'b0);
    hold(10);
    check("fwd500_feedback", int'(feedback), 500);
    check("fwd500_position", position, 500);

    // index coincident with step
    index_en = 1'b1;
    step(1'b1, 10, 1'b1);
    check("index_feedback", int'(feedback), 0);
    check("index_position", position, 501);
    check("index_seen", int'(index_seen), 1);
    index_en = 1'b0;
    step(1'b1, 10, 1'b1);
    check("noindex_feedback", int'(feedback), 1);
    check("noindex_position", position, 502);
    check("index_seen_sticky", int'(index_seen), 1);

    // velocity window
`ifdef ENCODER_VELOCITY_EN
    exp_vel = 50;
`else
    exp_vel = 0;
`endif
    wait_phase(5);
    for (int i = 0; i < 50; i++) step(1'b1, 6, 1'b0);
    wait_phase(2);
    check("velocity_50", int'(velocity), exp_vel);
    check("vel_feedback", int'(feedback), 51);
    wait_phase(2);
    check("velocity_idle", int'(velocity), 0);
    check("queue_drained", exp_q.size(), 0);

    // asynchronous reset mid-window
    wait_phase(400);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_feedback", int'(feedback), 0);
    check("async_position", position, 0);
    check("async_direction", int'(direction), 0);
    check("async_index_seen", int'(index_seen), 0);
    check("async_error", int'(error), 0);
    check("async_velocity", int'(velocity), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
